life_cell_gen: RTL and testbench

Parametrised Game-of-Life cell and the next generation of the board's per-cell block. It counts live neighbors over a configurable neighborhood and applies runtime-programmable birth/survival rule masks, replacing the hard-wired B3/S23 rule. It adds the "Generations" rule family, where a cell passes through multi-step dying states. It sits one instance per board position, driven by the shared step enable, and exposes both next-state and registered state to the grid and display logic.

---
 rtl/life_cell_gen.sv | 94 +++++++++
 tb/tb_life_cell_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/life_cell_gen.sv
// Game-of-Life / Generations cell with programmable birth/survive masks and
// neighbor popcount. Optional alive-age counter built when LIFE_CELL_AGE_EN is defined.
module life_cell_gen #(
   parameter  int N_NEIGHBORS = 8,
   parameter  int STATES      = 2,
   parameter  int AGE_W       = 8,
   localparam int CW          = $clog2(N_NEIGHBORS + 1),
   localparam int SW          = $clog2(STATES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ena,
   input  logic                   load,
   input  logic                   state_0,
   input  logic [N_NEIGHBORS:0]   birth_mask,
   input  logic [N_NEIGHBORS:0]   survive_mask,
   input  logic [N_NEIGHBORS-1:0] neighbors,
   output logic [CW-1:0]          living_neighbors,
   output logic [SW-1:0]          state_d,
   output logic [SW-1:0]          state_q,
   output logic                   alive_q,
   output logic                   changed_q,
   output logic [AGE_W-1:0]       age_q
);

   localparam logic [SW-1:0] ST_DEAD        = '0;
   localparam logic [SW-1:0] ST_ALIVE       = SW'(1);
   localparam logic [SW-1:0] ST_FIRST_DYING = SW'(2);
   localparam logic [SW-1:0] ST_LAST        = SW'(STATES - 1);

   always_comb begin
      living_neighbors = '0;
      for (int i = 0; i < N_NEIGHBORS; i++) begin
         living_neighbors = living_neighbors + CW'(neighbors[i]);
      end
   end

   // Dying cells ignore neighbors; out-of-range codes fall through to dead.
   always_comb begin
      state_d = ST_DEAD;
      if (state_q == ST_DEAD) begin
         state_d = birth_mask[living_neighbors] ? ST_ALIVE : ST_DEAD;
      end else if (state_q == ST_ALIVE) begin
         if (survive_mask[living_neighbors]) begin
            state_d = ST_ALIVE;
         end else if (STATES > 2) begin
            state_d = ST_FIRST_DYING;
         end else begin
            state_d = ST_DEAD;
         end
      end else if (state_q < ST_LAST) begin
         state_d = state_q + SW'(1);
      end else begin
         state_d = ST_DEAD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_DEAD;
         changed_q <= 1'b0;
      end else if (load) begin
         state_q   <= SW'(state_0);
         changed_q <= 1'b0;
      end else if (ena) begin
         state_q   <= state_d;
         changed_q <= (state_d != state_q);
      end
   end

   assign alive_q = (state_q == ST_ALIVE);

`ifdef LIFE_CELL_AGE_EN
   function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] v);
      return (&v) ? v : v + AGE_W'(1);
   endfunction

   logic [AGE_W-1:0] age_r;

   // A birth edge restarts at zero; only alive-to-alive steps count.
   always_ff @(posedge clk) begin
      if (rst || load) begin
         age_r <= '0;
      end else if (ena) begin
         age_r <= (state_d == ST_ALIVE && state_q == ST_ALIVE) ? sat_inc(age_r) : '0;
      end
   end

   assign age_q = age_r;
`else
   assign age_q = '0;
`endif

endmodule

// File: tb/tb_life_cell_gen.sv
// Self-checking bench: two cell configurations (Moore/Life and von Neumann/Generations)
// checked every cycle against a rule-level model, plus directed literal checks.
module tb_life_cell_gen;

`ifdef LIFE_CELL_AGE_EN
   localparam bit AGE_ON = 1'b1;
`else
   localparam bit AGE_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: Moore, classic two-state, 2-bit age
   logic       a_rst, a_ena, a_load, a_s0;
   logic [8:0] a_bm, a_sm;
   logic [7:0] a_nb;
   logic [3:0] a_ln;
   logic       a_sd, a_sq, a_alive, a_chg;
   logic [1:0] a_age;

   // Instance B: von Neumann, four-state Generations, 3-bit age
   logic       b_rst, b_ena, b_load, b_s0;
   logic [4:0] b_bm, b_sm;
   logic [3:0] b_nb;
   logic [2:0] b_ln;
   logic [1:0] b_sd, b_sq;
   logic       b_alive, b_chg;
   logic [2:0] b_age;

   life_cell_gen #(.N_NEIGHBORS(8), .STATES(2), .AGE_W(2)) u_a (
      .clk(clk), .rst(a_rst), .ena(a_ena), .load(a_load), .state_0(a_s0),
      .birth_mask(a_bm), .survive_mask(a_sm), .neighbors(a_nb),
      .living_neighbors(a_ln), .state_d(a_sd), .state_q(a_sq),
      .alive_q(a_alive), .changed_q(a_chg), .age_q(a_age)
   );

   life_cell_gen #(.N_NEIGHBORS(4), .STATES(4), .AGE_W(3)) u_b (
      .clk(clk), .rst(b_rst), .ena(b_ena), .load(b_load), .state_0(b_s0),
      .birth_mask(b_bm), .survive_mask(b_sm), .neighbors(b_nb),
      .living_neighbors(b_ln), .state_d(b_sd), .state_q(b_sq),
      .alive_q(b_alive), .changed_q(b_chg), .age_q(b_age)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int next_state(input int s, input int k, input logic [31:0] bm,
                                     input logic [31:0] sm, input int states);
      if (s == 0) return bm[k] ? 1 : 0;
      if (s == 1) return sm[k] ? 1 : ((states > 2) ? 2 : 0);
      if (s + 1 >= states) return 0;
      return s + 1;
   endfunction

   task automatic model_step(input logic rst, input logic load, input logic s0, input logic ena,
                             input int k, input logic [31:0] bm, input logic [31:0] sm,
                             input int states, input int amax,
                             inout int st, inout int age, inout int chg);
      int nd;
      if (rst) begin
         st = 0; age = 0; chg = 0;
      end else if (load) begin
         st = s0 ? 1 : 0; age = 0; chg = 0;
      end else if (ena) begin
         nd  = next_state(st, k, bm, sm, states);
         chg = (nd != st) ? 1 : 0;
         if (!AGE_ON) age = 0;
         else if (nd == 1 && st == 1) age = (age < amax) ? age + 1 : amax;
         else age = 0;
         st = nd;
      end
   endtask

   int ma_st, ma_age, ma_chg, mb_st, mb_age, mb_chg;
   bit m_ok = 1'b0;

   always @(posedge clk) begin
      model_step(a_rst, a_load, a_s0, a_ena, $countones(a_nb), a_bm, a_sm, 2, 3,
                 ma_st, ma_age, ma_chg);
      model_step(b_rst, b_load, b_s0, b_ena, $countones(b_nb), b_bm, b_sm, 4, 7,
                 mb_st, mb_age, mb_chg);
      if (a_rst && b_rst) m_ok = 1'b1;
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("a_living", a_ln, $countones(a_nb));
         chk("a_state_d", a_sd, next_state(ma_st, $countones(a_nb), a_bm, a_sm, 2));
         chk("a_state_q", a_sq, ma_st);
         chk("a_alive", a_alive, (ma_st == 1) ? 1 : 0);
         chk("a_changed", a_chg, ma_chg);
         chk("a_age", a_age, ma_age);
         chk("b_living", b_ln, $countones(b_nb));
         chk("b_state_d", b_sd, next_state(mb_st, $countones(b_nb), b_bm, b_sm, 4));
         chk("b_state_q", b_sq, mb_st);
         chk("b_alive", b_alive, (mb_st == 1) ? 1 : 0);
         chk("b_changed", b_chg, mb_chg);
         chk("b_age", b_age, mb_age);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int exp_age [5] = '{1, 2, 3, 3, 3};
      a_rst = 1; a_ena = 0; a_load = 0; a_s0 = 0; a_nb = '0;
      a_bm = 9'h008; a_sm = 9'h00C;
      b_rst = 1; b_ena = 0; b_load = 0; b_s0 = 0; b_nb = '0;
      b_bm = 5'b00100; b_sm = 5'b00000;
      tick(); tick();
      chk("lit_a_reset_state", a_sq, 0);
      chk("lit_a_reset_changed", a_chg, 0);
      chk("lit_a_reset_age", a_age, 0);
      chk("lit_b_reset_state", b_sq, 0);
      a_rst = 0; b_rst = 0;

      // classic B3/S23
      a_ena = 1; a_nb = 8'b0000_0111; tick();
      chk("lit_a_birth_state", a_sq, 1);
      chk("lit_a_birth_changed", a_chg, 1);
      chk("lit_a_birth_age", a_age, 0);
      a_nb = 8'b0000_1111; tick();
      chk("lit_a_overcrowd_state", a_sq, 0);
      chk("lit_a_overcrowd_changed", a_chg, 1);
      a_ena = 0; a_load = 1; a_s0 = 1; tick();
      a_load = 0;
      chk("lit_a_load_state", a_sq, 1);
      a_ena = 1; a_nb = 8'b0001_0100;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("lit_a_survive_state", a_sq, 1);
         chk("lit_a_survive_changed", a_chg, 0);
         chk("lit_a_age_sat", a_age, AGE_ON ? exp_age[i] : 0);
      end
      a_nb = 8'b0000_0000; tick();
      chk("lit_a_death_state", a_sq, 0);
      chk("lit_a_death_age", a_age, 0);

      // hold with changing neighbors
      a_ena = 0; a_load = 1; a_s0 = 1; tick();
      a_load = 0; a_ena = 1; a_nb = 8'b0000_0011; tick();
      a_ena = 0;
      for (int i = 0; i < 10; i++) begin
         a_nb = 8'($urandom);
         tick();
         chk("lit_a_hold_state", a_sq, 1);
         chk("lit_a_hold_changed", a_chg, 0);
         chk("lit_a_hold_age", a_age, AGE_ON ? 1 : 0);
      end

      // Generations decay, no rebirth while dying
      b_load = 1; b_s0 = 1; tick();
      b_load = 0;
      chk("lit_b_load_state", b_sq, 1);
      b_ena = 1; b_nb = 4'b1111; tick();
      chk("lit_b_decay1", b_sq, 2);
      b_nb = 4'b0011; tick();
      chk("lit_b_decay2", b_sq, 3);
      tick();
      chk("lit_b_decay3", b_sq, 0);
      tick();
      chk("lit_b_rebirth", b_sq, 1);

      // load beats ena, then reset beats ena
      tick(); tick();
      chk("lit_b_dying3", b_sq, 3);
      b_load = 1; b_s0 = 1; tick();
      chk("lit_b_prio_state", b_sq, 1);
      chk("lit_b_prio_age", b_age, 0);
      chk("lit_b_prio_changed", b_chg, 0);
      b_load = 0; b_rst = 1; tick();
      chk("lit_b_rst_state", b_sq, 0);
      chk("lit_b_rst_alive", b_alive, 0);
      chk("lit_b_rst_changed", b_chg, 0);
      chk("lit_b_rst_age", b_age, 0);
      b_rst = 0;

      // von Neumann
      b_ena = 0; b_sm = 5'b01100; b_load = 1; b_s0 = 1; tick();
      b_load = 0; b_nb = 4'b1111; #2;
      chk("lit_b_vn_count", b_ln, 4);
      chk("lit_b_vn_state_d", b_sd, 2);
      b_ena = 1; tick();
      chk("lit_b_vn_state_q", b_sq, 2);
      chk("lit_b_vn_alive", b_alive, 0);

      // randomized traffic on both instances
      for (int i = 0; i < 3000; i++) begin
         a_rst  = ($urandom_range(0, 63) == 0);
         a_load = ($urandom_range(0, 15) == 0);
         a_s0   = 1'($urandom);
         a_ena  = ($urandom_range(0, 3) != 0);
         a_nb   = 8'($urandom);
         if ($urandom_range(0, 31) == 0) begin
            a_bm = 9'($urandom);
            a_sm = 9'($urandom);
         end
         b_rst  = ($urandom_range(0, 63) == 0);
         b_load = ($urandom_range(0, 15) == 0);
         b_s0   = 1'($urandom);
         b_ena  = ($urandom_range(0, 3) != 0);
         b_nb   = 4'($urandom);
         if ($urandom_range(0, 31) == 0) begin
            b_bm = 5'($urandom);
            b_sm = 5'($urandom);
         end
         tick();
      end
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
